// File: rtl/fitness_evaluator.sv
// Fitness evaluator for a CGP node array: sweeps every input vector, compares the
// settled array outputs against a target truth table and reports the match count.
module fitness_evaluator #(
   parameter int inBit        = 4,
   parameter int outBit       = 1,
   parameter int settleCycles = 1,
   parameter int fitBit       = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [outBit-1:0]              blockResult,
   input  logic [(2**inBit)*outBit-1:0]   truthTable,
   output logic [inBit-1:0]               testVector,
   output logic                           busy,
   output logic                           done,
   output logic [fitBit-1:0]              fitness,
   output logic                           perfect
);

   localparam int N    = 2**inBit;
   localparam int CntW = (settleCycles > 1) ? $clog2(settleCycles) : 1;

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   state_t             state_q;
   logic [inBit-1:0]   testVector_q;
   logic [CntW-1:0]    cnt_q;
   logic [fitBit-1:0]  acc_q;
   logic [fitBit-1:0]  acc_d;
   logic               busy_q;
   logic               done_q;
   logic [fitBit-1:0]  fitness_q;
   logic               perfect_q;
   logic [outBit-1:0]  expBits;
   logic [outBit-1:0]  matchBits;
   logic [fitBit-1:0]  matchCnt;

   // Matching bits for the current vector; only consumed while in SAMPLE.
   always_comb begin
      expBits   = truthTable[int'(testVector_q)*outBit +: outBit];
      matchBits = ~(blockResult ^ expBits);
      matchCnt  = '0;
      for (int i = 0; i < outBit; i++) begin
         matchCnt = matchCnt + fitBit'(matchBits[i]);
      end
      acc_d = acc_q + matchCnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         testVector_q <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fitness_q    <= '0;
         perfect_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  testVector_q <= '0;
                  acc_q        <= '0;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= APPLY;
               end
            end
            APPLY: begin
               if (cnt_q == CntW'(settleCycles - 1)) begin
                  state_q <= SAMPLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SAMPLE: begin
               acc_q <= acc_d;
               // Final result is published on entry to DONE so it is valid with the pulse.
               if (testVector_q == inBit'(N - 1)) begin
                  done_q    <= 1'b1;
                  fitness_q <= acc_d;
                  perfect_q <= (acc_d == fitBit'(N * outBit));
                  state_q   <= DONE;
               end else begin
                  testVector_q <= testVector_q + 1'b1;
                  cnt_q        <= '0;
                  state_q      <= APPLY;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign testVector = testVector_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fitness    = fitness_q;
   assign perfect    = perfect_q;

endmodule
